// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: byte-command sequencer feeding an external ALU and returning its result as two bytes (optional frame timeout: ALU_CMD_TIMEOUT_EN)
module alu_cmd_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_valid,
  output logic [DATA_WIDTH-1:0]   alu_a,
  output logic [DATA_WIDTH-1:0]   alu_b,
  output logic [FUN_WIDTH-1:0]    alu_fun,
  output logic                    alu_en,
  input  logic [2*DATA_WIDTH-1:0] alu_out,
  input  logic                    alu_out_vld,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    err
);
  typedef enum logic [2:0] {IDLE, GET_A, GET_B, GET_FUN, ALU_RUN, ALU_WAIT, TX_LO, TX_HI} state_t;
  localparam logic [DATA_WIDTH-1:0] OP_FULL  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OP_REUSE = DATA_WIDTH'(8'hDD);
  state_t state, next;
  logic [2*DATA_WIDTH-1:0] result;
  logic err_next, tmo, xfer;
  assign xfer = tx_valid && tx_ready;
`ifdef ALU_CMD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic get;
  assign get = state inside {GET_A, GET_B, GET_FUN};
  assign tmo = get && !rx_valid && cnt == CW'(TIMEOUT_CYCLES - 1);
  // counts idle clocks inside a frame; any accepted byte or leaving the GET states restarts it
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else      cnt <= (get && !rx_valid && !tmo) ? cnt + 1'b1 : '0;
`else
  assign tmo = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= next;
  // next state and error detection; bytes arriving outside IDLE/GET states are dropped as errors
  always_comb begin
    next     = state;
    err_next = 1'b0;
    case (state)
      IDLE: if (rx_valid) begin
        next     = rx_data == OP_FULL ? GET_A : rx_data == OP_REUSE ? GET_FUN : IDLE;
        err_next = rx_data != OP_FULL && rx_data != OP_REUSE;
      end
      GET_A:    next = rx_valid ? GET_B   : tmo ? IDLE : state;
      GET_B:    next = rx_valid ? GET_FUN : tmo ? IDLE : state;
      GET_FUN:  next = rx_valid ? ALU_RUN : tmo ? IDLE : state;
      ALU_RUN:  next = ALU_WAIT;
      ALU_WAIT: next = alu_out_vld ? TX_LO : state;
      TX_LO:    next = xfer ? TX_HI : state;
      TX_HI:    next = xfer ? IDLE : state;
      default:  next = IDLE;
    endcase
    if (state inside {GET_A, GET_B, GET_FUN}) err_next = tmo;
    if (state inside {ALU_RUN, ALU_WAIT, TX_LO, TX_HI}) err_next = rx_valid;
  end
  // operand, function and result capture; operands persist across frames for 0xDD reuse
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_fun <= '0;
      result  <= '0;
      err     <= 1'b0;
    end else begin
      err <= err_next;
      if (rx_valid && state == GET_A)   alu_a   <= rx_data;
      if (rx_valid && state == GET_B)   alu_b   <= rx_data;
      if (rx_valid && state == GET_FUN) alu_fun <= rx_data[FUN_WIDTH-1:0];
      if (alu_out_vld && state == ALU_WAIT) result <= alu_out;
    end
  // outputs decoded from state; tx_data is a mux of the held result so it stays stable while stalled
  always_comb begin
    alu_en   = state == ALU_RUN;
    tx_valid = state == TX_LO || state == TX_HI;
    busy     = state != IDLE;
    tx_data  = state == TX_LO ? result[DATA_WIDTH-1:0] :
               state == TX_HI ? result[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
  end
endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb_alu_cmd_ctrl: directed self-checking bench with a small add/sub/mul ALU model
module tb_alu_cmd_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  alu_a, alu_b, tx_data;
  logic [3:0]  alu_fun;
  logic        alu_en, tx_valid, busy, err;
  logic [15:0] alu_out = '0;
  logic        alu_out_vld = 1'b0;
  logic        tx_ready = 1'b1;
  int checks = 0;
  int errors = 0;
  int en_cnt = 0;

  alu_cmd_ctrl #(.DATA_WIDTH(8), .FUN_WIDTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_en(alu_en),
    .alu_out(alu_out), .alu_out_vld(alu_out_vld),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // external ALU: fun 0 add, 1 sub, 2 mul, result one cycle after alu_en
  always @(posedge clk) begin
    alu_out_vld <= alu_en;
    alu_out <= alu_fun == 4'd0 ? 16'(alu_a) + 16'(alu_b) :
               alu_fun == 4'd1 ? 16'(alu_a) - 16'(alu_b) : 16'(alu_a) * 16'(alu_b);
    if (alu_en) en_cnt <= en_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input string tag);
    int n = 0;
    while (!tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_tx_valid_timeout"}, 32'(tx_valid), 32'd1);
  endtask

  task automatic recv(input string tag, input logic [7:0] exp);
    int n = 0;
    while (!(tx_valid && tx_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_xfer"}, 32'(tx_valid && tx_ready), 32'd1);
    chk(tag, 32'(tx_data), 32'(exp));
    @(negedge clk);
  endtask

  initial begin
    int en0;
    logic stable;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_outs", {alu_a, alu_b, 4'(alu_fun), 3'b0, alu_en, tx_data}, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    // CC,05,03,00: add
    en0 = en_cnt;
    send(8'hCC); send(8'h05); send(8'h03); send(8'h00);
    chk("f1_alu_en_latency", 32'(alu_en), 32'd1);
    chk("f1_ops", {16'h0, alu_a, alu_b}, 32'h0503);
    chk("f1_fun", 32'(alu_fun), 32'd0);
    recv("f1_lo", 8'h08);
    recv("f1_hi", 8'h00);
    chk("f1_tx_valid_after", 32'(tx_valid), 32'd0);
    chk("f1_busy_after", 32'(busy), 32'd0);
    chk("f1_en_pulses", 32'(en_cnt - en0), 32'd1);
    // CC,0A,03,02 mul then DD,01 sub with reused operands
    send(8'hCC); send(8'h0A); send(8'h03); send(8'h02);
    recv("f2_lo", 8'h1E);
    recv("f2_hi", 8'h00);
    send(8'hDD); send(8'h01);
    chk("f3_reuse_ops", {16'h0, alu_a, alu_b}, 32'h0A03);
    chk("f3_fun", 32'(alu_fun), 32'd1);
    recv("f3_lo", 8'h07);
    recv("f3_hi", 8'h00);
    // bad opcode
    en0 = en_cnt;
    send(8'h55);
    chk("bad_err_pulse", 32'(err), 32'd1);
    chk("bad_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("bad_err_one_cycle", 32'(err), 32'd0);
    chk("bad_no_alu_en", 32'(en_cnt - en0), 32'd0);
    // FF*FF with stalled transmit, plus a stray byte while stalled
    tx_ready = 1'b0;
    send(8'hCC); send(8'hFF); send(8'hFF); send(8'h02);
    wait_tx("f4");
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!tx_valid || tx_data !== 8'h01) stable = 1'b0;
      @(negedge clk);
    end
    chk("f4_stall_stable", 32'(stable), 32'd1);
    send(8'h77);
    chk("f4_stray_err", 32'(err), 32'd1);
    chk("f4_stray_state", {24'h0, tx_data}, 32'h01);
    tx_ready = 1'b1;
    recv("f4_lo", 8'h01);
    recv("f4_hi", 8'hFE);
    // asynchronous reset mid-frame
    send(8'hCC); send(8'h05);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_alu_a", 32'(alu_a), 32'h05);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_outs", {alu_a, alu_b, 4'(alu_fun), 1'b0, alu_en, busy, err, tx_data}, 32'd0);
    chk("async_rst_tx_valid", 32'(tx_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    send(8'hCC); send(8'h02); send(8'h02); send(8'h00);
    recv("f5_lo", 8'h04);
    recv("f5_hi", 8'h00);
`ifdef ALU_CMD_TIMEOUT_EN
    begin
      int n = 0;
      en0 = en_cnt;
      send(8'hCC); send(8'h05);
      while (!err && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("tmo_cycles", 32'(n), 32'd16);
      chk("tmo_idle", 32'(busy), 32'd0);
      chk("tmo_no_alu_en", 32'(en_cnt - en0), 32'd0);
      chk("tmo_alu_a_kept", 32'(alu_a), 32'h05);
    end
`else
    send(8'hCC); send(8'h05);
    repeat (40) @(negedge clk);
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_no_err", 32'(err), 32'd0);
    send(8'h03); send(8'h00);
    recv("f6_lo", 8'h08);
    recv("f6_hi", 8'h00);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_cmd_ctrl.md
ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set operand and received-byte width.
REQ-002 Parameter FUN_WIDTH, default 4, SHALL set ALU function-code width.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the frame-timeout limit in clocks (used only under ALU_CMD_TIMEOUT_EN).
REQ-004 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  SHALL be the reset, asynchronous, active-low.
REQ-006 Port rx_data  input  DATA_WIDTH  SHALL carry a received command byte.
REQ-007 Port rx_valid  input  1  SHALL be a one-cycle pulse qualifying rx_data.
REQ-008 Port alu_a, alu_b  output  DATA_WIDTH each  SHALL be the registered ALU operands.
REQ-009 Port alu_fun  output  FUN_WIDTH  SHALL be the registered ALU function code.
REQ-010 Port alu_en  output  1  SHALL be the ALU enable.
REQ-011 Port alu_out  input  2*DATA_WIDTH  SHALL carry the registered ALU result.
REQ-012 Port alu_out_vld  input  1  SHALL qualify alu_out.
REQ-013 Port tx_data  output  DATA_WIDTH  SHALL carry the result byte to transmit.
REQ-014 Port tx_valid / tx_ready  output / input  1 each  SHALL form the transmit handshake; a byte transfers on a clock where both are high.
REQ-015 Port busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-016 Port err  output  1  SHALL be a one-cycle pulse flagging a protocol error.

Function
REQ-017 States SHALL be IDLE, GET_A, GET_B, GET_FUN, ALU_RUN, ALU_WAIT, TX_LO, TX_HI.
REQ-018 IDLE on rx_valid: 0xCC -> GET_A; 0xDD -> GET_FUN; any other byte -> err pulse next cycle, remain IDLE.
REQ-019 GET_A / GET_B on rx_valid SHALL load alu_a / alu_b and advance to GET_B / GET_FUN.
REQ-020 GET_FUN on rx_valid SHALL load alu_fun from rx_data[FUN_WIDTH-1:0] (upper bits ignored) and go to ALU_RUN.
REQ-021 An 0xDD frame SHALL reuse alu_a/alu_b held from the last 0xCC frame (zero after reset).
REQ-022 ALU_RUN SHALL drive alu_en high for exactly one cycle, then go to ALU_WAIT.
REQ-023 ALU_WAIT SHALL capture alu_out into a 2*DATA_WIDTH result register on alu_out_vld and go to TX_LO; alu_en SHALL be low.
REQ-024 TX_LO SHALL present result[DATA_WIDTH-1:0] with tx_valid high; on transfer -> TX_HI.
REQ-025 TX_HI SHALL present result[2*DATA_WIDTH-1:DATA_WIDTH]; on transfer -> IDLE, tx_valid low the following cycle.
REQ-026 While tx_valid is high and tx_ready low, tx_data SHALL remain stable.
REQ-027 rx_valid arriving in ALU_RUN, ALU_WAIT, TX_LO or TX_HI SHALL be discarded and pulse err; state unaffected.
REQ-028 Command-to-ALU latency: alu_en SHALL rise the cycle after the FUN byte's rx_valid.

Reset
REQ-029 On rst low, state SHALL be IDLE and alu_a, alu_b, alu_fun, alu_en, result, tx_data, tx_valid, busy, err SHALL be 0, asynchronously, including mid-frame or mid-transmit.
REQ-030 After rst deassertion, the first accepted byte SHALL be treated as an opcode.

Configuration
REQ-031 With ALU_CMD_TIMEOUT_EN defined, a counter SHALL clear on every accepted byte in GET_A/GET_B/GET_FUN and, on reaching TIMEOUT_CYCLES without a byte, return to IDLE with an err pulse; operands already loaded are retained.
REQ-032 Without ALU_CMD_TIMEOUT_EN, no counter SHALL exist and GET states SHALL wait indefinitely.

Verification
REQ-033 Frame CC,05,03,00 with tx_ready=1 -> one alu_en pulse, alu_a=05, alu_b=03, alu_fun=0; tx bytes 08 then 00; busy low after.
REQ-034 Frame CC,0A,03,02 then DD,01 -> tx 1E,00 then 07,00; second frame shows alu_a=0A, alu_b=03.
REQ-035 Byte 55 in IDLE -> single err pulse, no alu_en, busy stays 0.
REQ-036 Frame CC,FF,FF,02 with tx_ready low 10 cycles -> tx_valid held, tx_data=01 stable; then 01, FE.
REQ-037 rst asserted after CC,05 -> all outputs 0; subsequent CC,02,02,00 -> tx 04,00.
REQ-038 With ALU_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16: CC,05 then idle 16 clocks -> err pulse, IDLE, no alu_en.
